// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the cache-line memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_WIDTH_DEF = 32;
   localparam int LINE_WIDTH_DEF = 256;
   localparam int CNT_WIDTH_DEF  = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

endpackage

// File: rtl/perf_counter.sv
// Saturating performance counter with synchronous clear (clear beats increment).
module perf_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] val);
      if (val == {WIDTH{1'b1}}) begin
         return val;
      end
      return val + WIDTH'(1);
   endfunction

   // Counter register: reset and clear both zero it, otherwise count events.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         count <= '0;
      end else if (inc) begin
         count <= sat_inc(count);
      end
   end

endmodule

// File: rtl/line_arbiter.sv
// Two-requester (L1I / L1D) arbiter for a shared cache-line memory port.
// Grants one whole transaction at a time, round-robin on ties, with
// grant and contention performance counters.
module line_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int LINE_WIDTH = LINE_WIDTH_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_read,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp,
   input  logic                  i_grant_clear,
   input  logic                  d_grant_clear,
   input  logic                  contention_clear,
   output logic [CNT_WIDTH-1:0]  i_grant_count,
   output logic [CNT_WIDTH-1:0]  d_grant_count,
   output logic [CNT_WIDTH-1:0]  contention_count
);

   arb_state_t state, next_state;
   req_id_t    last_grant, next_last_grant;
   logic       i_req, d_req;
   logic       i_grant_inc, d_grant_inc, contention_inc;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   // Read data goes to both requesters ungated; only resp qualifies it.
   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

   // State and round-robin pointer; the first tie after reset goes to I.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= REQ_D;
      end else begin
         state      <= next_state;
         last_grant <= next_last_grant;
      end
   end

   // Next-state, grant bookkeeping and memory-port drive.
   always_comb begin
      next_state      = state;
      next_last_grant = last_grant;
      i_grant_inc     = 1'b0;
      d_grant_inc     = 1'b0;
      contention_inc  = 1'b0;
      mem_address     = '0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_wdata       = '0;
      i_resp          = 1'b0;
      d_resp          = 1'b0;

      case (state)
         IDLE: begin
            // mem_resp is deliberately ignored here (stray/post-reset).
            if (i_req && d_req) begin
               contention_inc = 1'b1;
               if (last_grant == REQ_D) begin
                  next_state      = GRANT_I;
                  next_last_grant = REQ_I;
                  i_grant_inc     = 1'b1;
               end else begin
                  next_state      = GRANT_D;
                  next_last_grant = REQ_D;
                  d_grant_inc     = 1'b1;
               end
            end else if (i_req) begin
               next_state      = GRANT_I;
               next_last_grant = REQ_I;
               i_grant_inc     = 1'b1;
            end else if (d_req) begin
               next_state      = GRANT_D;
               next_last_grant = REQ_D;
               d_grant_inc     = 1'b1;
            end
         end
         GRANT_I: begin
            mem_address = i_addr;
            mem_read    = 1'b1;
            i_resp      = mem_resp;
            if (mem_resp) begin
               next_state = IDLE;
            end
         end
         GRANT_D: begin
            // A simultaneous read+write request is treated as a writeback.
            mem_address = d_addr;
            mem_write   = d_write;
            mem_read    = d_read & ~d_write;
            mem_wdata   = d_wdata;
            d_resp      = mem_resp;
            if (mem_resp) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase

      // While reset is held the port is quiet even if the state is stale.
      if (!rst_n) begin
         mem_address = '0;
         mem_read    = 1'b0;
         mem_write   = 1'b0;
         mem_wdata   = '0;
         i_resp      = 1'b0;
         d_resp      = 1'b0;
      end
   end

   perf_counter #(.WIDTH(CNT_WIDTH)) u_i_grant_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (i_grant_inc),
      .clear (i_grant_clear),
      .count (i_grant_count)
   );

   perf_counter #(.WIDTH(CNT_WIDTH)) u_d_grant_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (d_grant_inc),
      .clear (d_grant_clear),
      .count (d_grant_count)
   );

   perf_counter #(.WIDTH(CNT_WIDTH)) u_contention_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (contention_inc),
      .clear (contention_clear),
      .count (contention_count)
   );

endmodule

// File: tb/tb_line_arbiter.sv
// Directed testbench for line_arbiter. Inputs change on the falling edge,
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_line_arbiter;

   localparam int AW = 32;
   localparam int LW = 256;
   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] i_addr;
   logic          i_read;
   logic [LW-1:0] i_rdata;
   logic          i_resp;
   logic [AW-1:0] d_addr;
   logic          d_read;
   logic          d_write;
   logic [LW-1:0] d_wdata;
   logic [LW-1:0] d_rdata;
   logic          d_resp;
   logic [AW-1:0] mem_address;
   logic          mem_read;
   logic          mem_write;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata;
   logic          mem_resp;
   logic          i_grant_clear;
   logic          d_grant_clear;
   logic          contention_clear;
   logic [CW-1:0] i_grant_count;
   logic [CW-1:0] d_grant_count;
   logic [CW-1:0] contention_count;

   int n_checks;
   int n_errors;

   localparam logic [LW-1:0] LINE_A5  = {32{8'hA5}};
   localparam logic [LW-1:0] LINE_PAT = {4{64'h0123_4567_89AB_CDEF}};
   localparam logic [AW-1:0] ADDR_I   = 32'h0000_1000;
   localparam logic [AW-1:0] ADDR_D   = 32'h0000_2020;

   line_arbiter #(
      .ADDR_WIDTH (AW),
      .LINE_WIDTH (LW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_addr           (i_addr),
      .i_read           (i_read),
      .i_rdata          (i_rdata),
      .i_resp           (i_resp),
      .d_addr           (d_addr),
      .d_read           (d_read),
      .d_write          (d_write),
      .d_wdata          (d_wdata),
      .d_rdata          (d_rdata),
      .d_resp           (d_resp),
      .mem_address      (mem_address),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .mem_wdata        (mem_wdata),
      .mem_rdata        (mem_rdata),
      .mem_resp         (mem_resp),
      .i_grant_clear    (i_grant_clear),
      .d_grant_clear    (d_grant_clear),
      .contention_clear (contention_clear),
      .i_grant_count    (i_grant_count),
      .d_grant_count    (d_grant_count),
      .contention_count (contention_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Holds reset for two rising edges and releases it on a falling edge.
   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One complete L1I read transaction, drive only.
   task automatic run_i_txn();
      i_read = 1'b1;
      @(negedge clk);
      mem_resp = 1'b1;
      @(negedge clk);
      mem_resp = 1'b0;
      i_read   = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      i_read = 1'b1; d_write = 1'b1; mem_resp = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         n_errors++; $display("FAIL reset_rw: read=%b write=%b want 0 0", mem_read, mem_write);
      end
      n_checks++;
      if (mem_address !== '0 || mem_wdata !== '0) begin
         n_errors++; $display("FAIL reset_addr: addr=%h want 0", mem_address);
      end
      n_checks++;
      if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
         n_errors++; $display("FAIL reset_resp: i=%b d=%b want 0 0", i_resp, d_resp);
      end
      n_checks++;
      if (i_grant_count !== '0 || d_grant_count !== '0 || contention_count !== '0) begin
         n_errors++; $display("FAIL reset_cnt: %0d %0d %0d want 0 0 0", i_grant_count, d_grant_count, contention_count);
      end
      i_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_read();
      apply_reset();
      i_read = 1'b1;
      i_addr = ADDR_I;
      #1;
      n_checks++;
      if (mem_read !== 1'b0) begin
         n_errors++; $display("FAIL read_latency0: mem_read=%b want 0", mem_read);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== ADDR_I) begin
         n_errors++; $display("FAIL read_issue: rd=%b wr=%b addr=%h want 1 0 %h", mem_read, mem_write, mem_address, ADDR_I);
      end
      n_checks++;
      if (i_grant_count !== 4'd1) begin
         n_errors++; $display("FAIL read_icount: %0d want 1", i_grant_count);
      end
      @(negedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (i_resp !== 1'b0) begin
         n_errors++; $display("FAIL read_noresp: i_resp=%b want 0", i_resp);
      end
      @(negedge clk);
      mem_resp  = 1'b1;
      mem_rdata = LINE_A5;
      #1;
      n_checks++;
      if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
         n_errors++; $display("FAIL read_resp: i=%b d=%b want 1 0", i_resp, d_resp);
      end
      n_checks++;
      if (i_rdata !== LINE_A5 || d_rdata !== LINE_A5) begin
         n_errors++; $display("FAIL read_rdata: i=%h want %h", i_rdata, LINE_A5);
      end
      @(negedge clk);
      mem_resp = 1'b0;
      i_read   = 1'b0;
      #1;
      n_checks++;
      if (mem_read !== 1'b0 || i_resp !== 1'b0) begin
         n_errors++; $display("FAIL read_done: rd=%b resp=%b want 0 0", mem_read, i_resp);
      end
   endtask

   task automatic test_write();
      d_write = 1'b1;
      d_addr  = ADDR_D;
      d_wdata = LINE_PAT;
      @(negedge clk);
      #1;
      n_checks++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== ADDR_D) begin
         n_errors++; $display("FAIL write_issue: wr=%b rd=%b addr=%h want 1 0 %h", mem_write, mem_read, mem_address, ADDR_D);
      end
      n_checks++;
      if (mem_wdata !== LINE_PAT) begin
         n_errors++; $display("FAIL write_wdata: %h want %h", mem_wdata, LINE_PAT);
      end
      mem_resp = 1'b1;
      #1;
      n_checks++;
      if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
         n_errors++; $display("FAIL write_resp: d=%b i=%b want 1 0", d_resp, i_resp);
      end
      @(negedge clk);
      mem_resp = 1'b0;
      d_write  = 1'b0;
      @(negedge clk);
      // Read and write together: the write must win.
      d_read  = 1'b1;
      d_write = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0) begin
         n_errors++; $display("FAIL write_priority: wr=%b rd=%b want 1 0", mem_write, mem_read);
      end
      mem_resp = 1'b1;
      @(negedge clk);
      mem_resp = 1'b0;
      d_read   = 1'b0;
      d_write  = 1'b0;
      #1;
      n_checks++;
      if (d_grant_count !== 4'd2 || i_grant_count !== 4'd1 || contention_count !== 4'd0) begin
         n_errors++; $display("FAIL write_counts: i=%0d d=%0d c=%0d want 1 2 0", i_grant_count, d_grant_count, contention_count);
      end
   endtask

   task automatic test_contention();
      logic [AW-1:0] want_addr;
      apply_reset();
      i_addr = ADDR_I;
      d_addr = ADDR_D;
      i_read = 1'b1;
      d_read = 1'b1;
      for (int k = 0; k < 4; k++) begin
         want_addr = (k % 2 == 0) ? ADDR_I : ADDR_D;
         @(negedge clk);
         #1;
         n_checks++;
         if (mem_address !== want_addr || mem_read !== 1'b1) begin
            n_errors++; $display("FAIL rr_grant%0d: addr=%h rd=%b want %h 1", k, mem_address, mem_read, want_addr);
         end
         n_checks++;
         if (contention_count !== CW'(k + 1)) begin
            n_errors++; $display("FAIL rr_contention%0d: %0d want %0d", k, contention_count, k + 1);
         end
         mem_resp = 1'b1;
         #1;
         n_checks++;
         if (i_resp !== (k % 2 == 0) || d_resp !== (k % 2 == 1)) begin
            n_errors++; $display("FAIL rr_resp%0d: i=%b d=%b", k, i_resp, d_resp);
         end
         @(negedge clk);
         mem_resp = 1'b0;
         #1;
         n_checks++;
         if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            n_errors++; $display("FAIL rr_gap%0d: rd=%b wr=%b want 0 0", k, mem_read, mem_write);
         end
      end
      i_read = 1'b0;
      d_read = 1'b0;
      #1;
      n_checks++;
      if (i_grant_count !== 4'd2 || d_grant_count !== 4'd2) begin
         n_errors++; $display("FAIL rr_counts: i=%0d d=%0d want 2 2", i_grant_count, d_grant_count);
      end
      @(negedge clk);
   endtask

   task automatic test_stray_resp();
      mem_resp = 1'b1;
      #1;
      n_checks++;
      if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
         n_errors++; $display("FAIL stray_resp: i=%b d=%b want 0 0", i_resp, d_resp);
      end
      @(negedge clk);
      mem_resp = 1'b0;
      #1;
      n_checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== '0) begin
         n_errors++; $display("FAIL stray_idle: rd=%b wr=%b addr=%h want idle", mem_read, mem_write, mem_address);
      end
      // A following request still issues with one cycle of latency.
      i_read = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if (mem_read !== 1'b1) begin
         n_errors++; $display("FAIL stray_next: rd=%b want 1", mem_read);
      end
      mem_resp = 1'b1;
      @(negedge clk);
      mem_resp = 1'b0;
      i_read   = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      d_write = 1'b1;
      d_addr  = ADDR_D;
      @(negedge clk);
      #1;
      n_checks++;
      if (mem_write !== 1'b1) begin
         n_errors++; $display("FAIL rstmid_pre: wr=%b want 1", mem_write);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n   = 1'b1;
      d_write = 1'b0;
      #1;
      n_checks++;
      if (mem_write !== 1'b0 || mem_read !== 1'b0 || d_resp !== 1'b0) begin
         n_errors++; $display("FAIL rstmid_port: wr=%b rd=%b want 0 0", mem_write, mem_read);
      end
      n_checks++;
      if (i_grant_count !== '0 || d_grant_count !== '0 || contention_count !== '0) begin
         n_errors++; $display("FAIL rstmid_cnt: %0d %0d %0d want 0 0 0", i_grant_count, d_grant_count, contention_count);
      end
      mem_resp = 1'b1;
      #1;
      n_checks++;
      if (d_resp !== 1'b0) begin
         n_errors++; $display("FAIL rstmid_idle: d_resp=%b want 0", d_resp);
      end
      @(negedge clk);
      mem_resp = 1'b0;
   endtask

   task automatic test_saturation();
      apply_reset();
      for (int k = 0; k < 14; k++) begin
         run_i_txn();
      end
      n_checks++;
      if (i_grant_count !== 4'd14) begin
         n_errors++; $display("FAIL sat_pre: %0d want 14", i_grant_count);
      end
      run_i_txn();
      run_i_txn();
      n_checks++;
      if (i_grant_count !== 4'd15) begin
         n_errors++; $display("FAIL sat_hold: %0d want 15", i_grant_count);
      end
      i_read        = 1'b1;
      i_grant_clear = 1'b1;
      @(negedge clk);
      i_grant_clear = 1'b0;
      #1;
      n_checks++;
      if (i_grant_count !== 4'd0 || mem_read !== 1'b1) begin
         n_errors++; $display("FAIL sat_clear: cnt=%0d rd=%b want 0 1", i_grant_count, mem_read);
      end
      mem_resp = 1'b1;
      @(negedge clk);
      mem_resp = 1'b0;
      i_read   = 1'b0;
      @(negedge clk);
      n_checks++;
      if (i_grant_count !== 4'd0) begin
         n_errors++; $display("FAIL sat_after: %0d want 0", i_grant_count);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      i_addr = '0; i_read = 1'b0;
      d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
      mem_rdata = '0; mem_resp = 1'b0;
      i_grant_clear = 1'b0; d_grant_clear = 1'b0; contention_clear = 1'b0;
      test_reset();
      test_read();
      test_write();
      test_contention();
      test_stray_resp();
      test_reset_mid();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
